// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the execute stage.
// One op is accepted on a start/done handshake. Multiplies finish in two
// cycles. Divide-by-zero and signed overflow finish in one cycle. All other
// divides use a restoring radix-2 divider: XLEN steps, one sign-fix cycle,
// then the done cycle.

package mdu_pkg;
    typedef enum logic [2:0] {
        MDU_MUL  = 3'd0,
        MDU_MULW = 3'd1,
        MDU_DIV  = 3'd2,
        MDU_REM  = 3'd3,
        MDU_REMU = 3'd4
    } mdu_op_t;
endpackage

module mdu_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO_VAL = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE_VAL  = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    mdu_op_t         op_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic [CW-1:0]   cnt_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            busy_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            is_mul_s;
    logic            is_signed_div_s;
    logic            b_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN-1:0] mul_lo_s;
    logic [31:0]     mulw_lo_s;
    logic [XLEN-1:0] mul_res_s;
    logic [XLEN:0]   shift_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_step_s;
    logic [XLEN-1:0] quo_step_s;
    logic [XLEN-1:0] q_fix_s;
    logic [XLEN-1:0] r_fix_s;
    logic [XLEN-1:0] fix_res_s;
    logic [XLEN-1:0] res_next_s;

    // An op is only taken from IDLE, and flush blocks a same-cycle start.
    assign accept_s        = (state_r == IDLE) && start && !flush;
    assign is_mul_s        = (op == MDU_MUL) || (op == MDU_MULW);
    assign is_signed_div_s = (op == MDU_DIV) || (op == MDU_REM);
    assign b_zero_s        = (b == ZERO_VAL);
    assign ovf_s           = is_signed_div_s && (a == MIN_VAL) && (b == ONES_VAL);

    assign abs_a_s = a[XLEN-1] ? (~a + ONE_VAL) : a;
    assign abs_b_s = b[XLEN-1] ? (~b + ONE_VAL) : b;

    // The product is evaluated in an XLEN-wide context. That yields exactly the
    // low half of the full double-width product, which is the only part kept.
    assign mul_lo_s  = a_r * b_r;
    assign mulw_lo_s = a_r[31:0] * b_r[31:0];
    assign mul_res_s = (op_r == MDU_MULW) ? {{(XLEN-32){mulw_lo_s[31]}}, mulw_lo_s} : mul_lo_s;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, then subtract the divisor when it fits.
    assign shift_s    = {rem_r, quo_r[XLEN-1]};
    assign ge_s       = (shift_s >= {1'b0, dvs_r});
    assign rem_step_s = ge_s ? (shift_s[XLEN-1:0] - dvs_r) : shift_s[XLEN-1:0];
    assign quo_step_s = {quo_r[XLEN-2:0], ge_s};

    // Apply the sign fix to the magnitude results. The neg flags stay clear for REMU.
    assign q_fix_s   = neg_q_r ? (~quo_r + ONE_VAL) : quo_r;
    assign r_fix_s   = neg_r_r ? (~rem_r + ONE_VAL) : rem_r;
    assign fix_res_s = (op_r == MDU_DIV) ? q_fix_s : r_fix_s;

    // Results for ops that skip the iterative divider.
    always_comb begin
        special_res_s = ZERO_VAL;
        if (b_zero_s) begin
            special_res_s = (op == MDU_DIV) ? ONES_VAL : a;
        end else if (ovf_s) begin
            special_res_s = (op == MDU_DIV) ? MIN_VAL : ZERO_VAL;
        end else begin
            special_res_s = ZERO_VAL;
        end
    end

    // Next-state logic, and selection of the result to register on entry to DONE.
    always_comb begin
        state_next_s = state_r;
        res_next_s   = result_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_mul_s) begin
                        state_next_s = MUL;
                    end else if (b_zero_s || ovf_s) begin
                        state_next_s = DONE;
                        res_next_s   = special_res_s;
                    end else begin
                        state_next_s = DIV;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                    res_next_s   = mul_res_s;
                end
            end
            DIV: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = DIV;
                end
            end
            FIX: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                    res_next_s   = fix_res_s;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_VAL;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= (state_next_s != IDLE) && (state_next_s != DONE);
            done_r   <= (state_next_s == DONE);
            if (state_next_s == DONE) begin
                result_r <= res_next_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    // Operand latch on accept, and one divider step per DIV cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= MDU_MUL;
            a_r     <= ZERO_VAL;
            b_r     <= ZERO_VAL;
            rem_r   <= ZERO_VAL;
            quo_r   <= ZERO_VAL;
            dvs_r   <= ZERO_VAL;
            cnt_r   <= {CW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
            rem_r   <= ZERO_VAL;
            quo_r   <= (op == MDU_REMU) ? a : abs_a_s;
            dvs_r   <= (op == MDU_REMU) ? b : abs_b_s;
            cnt_r   <= CW'(XLEN - 1);
            neg_q_r <= is_signed_div_s && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_r <= is_signed_div_s && a[XLEN-1];
        end else if (state_r == DIV) begin
            rem_r   <= rem_step_s;
            quo_r   <= quo_step_s;
            cnt_r   <= cnt_r - CW'(1);
        end else begin
            rem_r   <= rem_r;
            quo_r   <= quo_r;
            cnt_r   <= cnt_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
